// File: rtl/cache_axi_bridge.sv
// Bridges the core's icache/dcache/uncache rd/wr request ports onto one AXI3 master (1 read + 1 write outstanding).
// Latency: request grant is combinational; AR/AW issue the next cycle; read beats pass through to ret_* with zero added delay.
// Backpressure: rd/wr rdy are low while the owning FSM is busy; AR/AW/W valid and payload hold steady until the slave's ready.
module cache_axi_bridge #(
  parameter int LINE_WORDS = 8,
  parameter int RAW_CHECK  = 1
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  // IF read request port
  input  logic                    inst_rd_req,
  input  logic [2:0]              inst_rd_type,
  input  logic [31:0]             inst_rd_addr,
  output logic                    inst_rd_rdy,
  output logic                    inst_ret_valid,
  output logic                    inst_ret_last,
  // MEM read request port
  input  logic                    data_rd_req,
  input  logic [2:0]              data_rd_type,
  input  logic [31:0]             data_rd_addr,
  output logic                    data_rd_rdy,
  output logic                    data_ret_valid,
  output logic                    data_ret_last,
  output logic [31:0]             ret_data,
  // MEM write request port
  input  logic                    data_wr_req,
  input  logic [2:0]              data_wr_type,
  input  logic [31:0]             data_wr_addr,
  input  logic [3:0]              data_wr_wstrb,
  input  logic [32*LINE_WORDS-1:0] data_wr_data,
  output logic                    data_wr_rdy,
  // AXI read address channel
  output logic [3:0]              arid,
  output logic [31:0]             araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic [1:0]              arlock,
  output logic [3:0]              arcache,
  output logic [2:0]              arprot,
  output logic                    arvalid,
  input  logic                    arready,
  // AXI read data channel
  input  logic [3:0]              rid,
  input  logic [31:0]             rdata,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready,
  // AXI write address channel
  output logic [3:0]              awid,
  output logic [31:0]             awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic [1:0]              awlock,
  output logic [3:0]              awcache,
  output logic [2:0]              awprot,
  output logic                    awvalid,
  input  logic                    awready,
  // AXI write data channel
  output logic [31:0]             wdata,
  output logic [3:0]              wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  // AXI write response channel
  input  logic                    bvalid,
  output logic                    bready
);

  // Byte-offset bits within a cache line; line-type requests clear these.
  localparam int         OFF_W    = $clog2(LINE_WORDS * 4);
  localparam int         IDX_W    = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [7:0] LINE_LEN = 8'(LINE_WORDS - 1);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} wr_state_t;

  rd_state_t rd_state, rd_next;
  wr_state_t wr_state, wr_next;

  logic        data_grant;
  logic        inst_grant;
  logic        wr_grant;
  logic        raw_hit;
  logic        r_hit;
  logic        wr_line;
  logic [3:0]  wstrb_q;
  logic [7:0]  wcnt;
  logic [31:0] wr_words [LINE_WORDS];

  // Line requests (type[2]) are word-aligned bursts; byte/half/word go out as-is.
  function automatic logic [31:0] map_addr(input logic line, input logic [31:0] a);
    return line ? {a[31:OFF_W], {OFF_W{1'b0}}} : a;
  endfunction

  function automatic logic [7:0] map_len(input logic line);
    return line ? LINE_LEN : 8'd0;
  endfunction

  function automatic logic [2:0] map_size(input logic [2:0] t);
    return t[2] ? 3'd2 : {1'b0, t[1:0]};
  endfunction

  // AXI sideband: INCR bursts, writes tagged with id 1, everything else idle.
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign awid    = 4'd1;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;

  // A data read that hits the line still being written must wait for its B response.
  assign raw_hit = (RAW_CHECK != 0) && (wr_state != W_IDLE) &&
                   (data_rd_addr[31:OFF_W] == awaddr[31:OFF_W]);

  // Read beats are only returned when they carry the id of the granted client.
  assign r_hit          = (rd_state == R_DATA) && rvalid && (rid == arid);
  assign inst_ret_valid = r_hit && !arid[0];
  assign data_ret_valid = r_hit &&  arid[0];
  assign inst_ret_last  = inst_ret_valid && rlast;
  assign data_ret_last  = data_ret_valid && rlast;
  assign ret_data       = r_hit ? rdata : 32'd0;

  // Write beat mux: line writes always send full strobes.
  assign wdata = wr_words[wcnt[IDX_W-1:0]];
  assign wstrb = wr_line ? 4'b1111 : wstrb_q;
  assign wlast = (wr_state == W_DATA) && (wcnt == awlen);

  // Read FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) rd_state <= R_IDLE;
    else          rd_state <= rd_next;
  end

  // Read FSM next state, arbitration and channel handshakes.
  always_comb begin
    rd_next     = rd_state;
    data_grant  = 1'b0;
    inst_grant  = 1'b0;
    arvalid     = 1'b0;
    rready      = 1'b0;
    inst_rd_rdy = 1'b0;
    data_rd_rdy = 1'b0;
    case (rd_state)
      R_IDLE: begin
        // Data wins; a RAW-stalled data read does not block the inst side.
        data_grant = aresetn && data_rd_req && !raw_hit;
        inst_grant = aresetn && inst_rd_req && !data_grant;
        data_rd_rdy = data_grant;
        inst_rd_rdy = inst_grant;
        if (data_grant || inst_grant) rd_next = R_AR;
      end
      R_AR: begin
        arvalid = 1'b1;
        if (arready) rd_next = R_DATA;
      end
      R_DATA: begin
        rready = 1'b1;
        if (r_hit && rlast) rd_next = R_IDLE;
      end
      default: rd_next = R_IDLE;
    endcase
  end

  // Read address registers, captured on grant and held through R_AR.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      arid   <= 4'd0;
      araddr <= 32'd0;
      arlen  <= 8'd0;
      arsize <= 3'd0;
    end else if (data_grant) begin
      arid   <= 4'd1;
      araddr <= map_addr(data_rd_type[2], data_rd_addr);
      arlen  <= map_len(data_rd_type[2]);
      arsize <= map_size(data_rd_type);
    end else if (inst_grant) begin
      arid   <= 4'd0;
      araddr <= map_addr(inst_rd_type[2], inst_rd_addr);
      arlen  <= map_len(inst_rd_type[2]);
      arsize <= map_size(inst_rd_type);
    end
  end

  // Write FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) wr_state <= W_IDLE;
    else          wr_state <= wr_next;
  end

  // Write FSM next state and AW/W/B handshakes.
  always_comb begin
    wr_next     = wr_state;
    wr_grant    = 1'b0;
    data_wr_rdy = 1'b0;
    awvalid     = 1'b0;
    wvalid      = 1'b0;
    bready      = 1'b0;
    case (wr_state)
      W_IDLE: begin
        wr_grant    = aresetn && data_wr_req;
        data_wr_rdy = wr_grant;
        if (wr_grant) wr_next = W_AW;
      end
      W_AW: begin
        awvalid = 1'b1;
        if (awready) wr_next = W_DATA;
      end
      W_DATA: begin
        wvalid = 1'b1;
        if (wready && wlast) wr_next = W_RESP;
      end
      W_RESP: begin
        bready = 1'b1;
        if (bvalid) wr_next = W_IDLE;
      end
      default: wr_next = W_IDLE;
    endcase
  end

  // Write request capture (whole line payload) and beat counter.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      awaddr  <= 32'd0;
      awlen   <= 8'd0;
      awsize  <= 3'd0;
      wr_line <= 1'b0;
      wstrb_q <= 4'd0;
      wcnt    <= 8'd0;
      for (int i = 0; i < LINE_WORDS; i++) wr_words[i] <= 32'd0;
    end else if (wr_grant) begin
      awaddr  <= map_addr(data_wr_type[2], data_wr_addr);
      awlen   <= map_len(data_wr_type[2]);
      awsize  <= map_size(data_wr_type);
      wr_line <= data_wr_type[2];
      wstrb_q <= data_wr_wstrb;
      wcnt    <= 8'd0;
      for (int i = 0; i < LINE_WORDS; i++) wr_words[i] <= data_wr_data[i*32 +: 32];
    end else if (wvalid && wready) begin
      wcnt <= wcnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Self-checking bench for cache_axi_bridge: table-driven read/write transactions,
// hand-written arbitration, RAW-stall and mid-burst reset sequences.
// Read beats are checked through an expected-beat queue filled as the bench drives R.
module tb_cache_axi_bridge;
  localparam int LW = 8;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic aresetn;
  logic inst_rd_req, inst_rd_rdy, inst_ret_valid, inst_ret_last;
  logic [2:0] inst_rd_type;
  logic [31:0] inst_rd_addr;
  logic data_rd_req, data_rd_rdy, data_ret_valid, data_ret_last;
  logic [2:0] data_rd_type;
  logic [31:0] data_rd_addr, ret_data;
  logic data_wr_req, data_wr_rdy;
  logic [2:0] data_wr_type;
  logic [31:0] data_wr_addr;
  logic [3:0] data_wr_wstrb;
  logic [32*LW-1:0] data_wr_data;
  logic [3:0] arid, rid, awid, arcache, awcache, wstrb;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, awsize, arprot, awprot;
  logic [1:0] arburst, arlock, awburst, awlock;
  logic arvalid, arready, rlast, rvalid, rready;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  cache_axi_bridge #(.LINE_WORDS(LW), .RAW_CHECK(1)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .inst_rd_req(inst_rd_req), .inst_rd_type(inst_rd_type), .inst_rd_addr(inst_rd_addr),
    .inst_rd_rdy(inst_rd_rdy), .inst_ret_valid(inst_ret_valid), .inst_ret_last(inst_ret_last),
    .data_rd_req(data_rd_req), .data_rd_type(data_rd_type), .data_rd_addr(data_rd_addr),
    .data_rd_rdy(data_rd_rdy), .data_ret_valid(data_ret_valid), .data_ret_last(data_ret_last),
    .ret_data(ret_data),
    .data_wr_req(data_wr_req), .data_wr_type(data_wr_type), .data_wr_addr(data_wr_addr),
    .data_wr_wstrb(data_wr_wstrb), .data_wr_data(data_wr_data), .data_wr_rdy(data_wr_rdy),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  int checks = 0;
  int failures = 0;

  typedef struct { logic is_data; logic [31:0] data; logic last; } beat_t;
  beat_t exp_q[$];

  typedef struct {
    logic is_data; logic [2:0] typ; logic [31:0] addr; int ar_delay;
    logic [31:0] exp_addr; logic [7:0] exp_len; logic [2:0] exp_size; int beats;
  } rd_vec_t;

  typedef struct {
    logic [2:0] typ; logic [31:0] addr; logic [3:0] strb; logic [31:0] seed;
    logic [31:0] exp_addr; logic [7:0] exp_len; logic [2:0] exp_size; logic [3:0] exp_strb;
    logic toggle; int b_delay;
  } wr_vec_t;

  rd_vec_t rv [5];
  wr_vec_t wv [3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [32*LW-1:0] mk_payload(input logic [31:0] seed);
    logic [32*LW-1:0] p;
    for (int k = 0; k < LW; k++) p[k*32 +: 32] = seed + k;
    return p;
  endfunction

  // Every returned beat must match the oldest beat the bench drove on R.
  always @(negedge aclk) begin
    beat_t e;
    if (inst_ret_valid || data_ret_valid) begin
      if (exp_q.size() == 0) begin
        check("ret_unexpected", {62'd0, data_ret_valid, inst_ret_valid}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("ret_owner", {data_ret_valid, inst_ret_valid}, e.is_data ? 2'b10 : 2'b01);
        check("ret_data", ret_data, e.data);
        check("ret_last", e.is_data ? data_ret_last : inst_ret_last, e.last);
      end
    end
  end

  task automatic rd_start(input logic is_data, input logic [2:0] t, input logic [31:0] a);
    if (is_data) begin data_rd_req = 1; data_rd_type = t; data_rd_addr = a; end
    else begin inst_rd_req = 1; inst_rd_type = t; inst_rd_addr = a; end
    @(negedge aclk);
    check("rd_rdy_owner", is_data ? data_rd_rdy : inst_rd_rdy, 1);
    check("rd_rdy_other", is_data ? inst_rd_rdy : data_rd_rdy, 0);
    tick();
    data_rd_req = 0;
    inst_rd_req = 0;
  endtask

  task automatic ar_phase(input int delay, input logic [31:0] ea, input logic [7:0] el,
                          input logic [2:0] es, input logic [3:0] eid);
    for (int i = 0; i <= delay; i++) begin
      arready = (i == delay);
      @(negedge aclk);
      check("arvalid", arvalid, 1);
      check("araddr", araddr, ea);
      check("arlen", arlen, el);
      check("arsize", arsize, es);
      check("arid", arid, eid);
      tick();
    end
    arready = 0;
  endtask

  task automatic r_phase(input int n_send, input int n_total, input logic [3:0] id, input logic is_data);
    for (int i = 0; i < n_send; i++) begin
      rvalid = 1; rid = id; rdata = $urandom; rlast = (i == n_total - 1);
      exp_q.push_back('{is_data, rdata, rlast});
      @(negedge aclk);
      check("rready", rready, 1);
      tick();
    end
    rvalid = 0;
    rlast = 0;
  endtask

  // Accepts a write and keeps the request asserted with scrambled contents.
  task automatic wr_start(input logic [2:0] t, input logic [31:0] a, input logic [3:0] s,
                          input logic [32*LW-1:0] p);
    data_wr_req = 1; data_wr_type = t; data_wr_addr = a; data_wr_wstrb = s; data_wr_data = p;
    @(negedge aclk);
    check("wr_rdy_accept", data_wr_rdy, 1);
    tick();
    data_wr_data = ~p; data_wr_wstrb = ~s; data_wr_addr = a ^ 32'h40;
  endtask

  task automatic aw_phase(input int delay, input logic [31:0] ea, input logic [7:0] el, input logic [2:0] es);
    for (int i = 0; i <= delay; i++) begin
      awready = (i == delay);
      @(negedge aclk);
      check("awvalid", awvalid, 1);
      check("awaddr", awaddr, ea);
      check("awlen", awlen, el);
      check("awsize", awsize, es);
      check("wr_rdy_aw", data_wr_rdy, 0);
      tick();
    end
    awready = 0;
  endtask

  task automatic w_phase(input int n, input logic [31:0] seed, input logic [3:0] es, input logic toggle);
    int idx = 0;
    for (int c = 0; c < 4 * LW && idx < n; c++) begin
      wready = !toggle || (c % 2 == 0);
      @(negedge aclk);
      check("wvalid", wvalid, 1);
      check("wdata", wdata, seed + idx);
      check("wlast", wlast, idx == n - 1);
      check("wstrb", wstrb, es);
      check("wr_rdy_w", data_wr_rdy, 0);
      tick();
      if (wready) idx++;
    end
    wready = 0;
    check("w_beat_count", idx, n);
  endtask

  task automatic b_phase(input int delay);
    for (int i = 0; i <= delay; i++) begin
      bvalid = (i == delay);
      @(negedge aclk);
      check("bready", bready, 1);
      check("wvalid_resp", wvalid, 0);
      check("wr_rdy_resp", data_wr_rdy, 0);
      tick();
    end
    bvalid = 0;
    @(negedge aclk);
    check("wr_rdy_after_b", data_wr_rdy, 1);
    #1 data_wr_req = 0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    rv[0] = '{1'b0, 3'b100, 32'h1FC0_0010, 2, 32'h1FC0_0000, 8'd7, 3'd2, 8};
    rv[1] = '{1'b1, 3'b000, 32'h8000_0003, 0, 32'h8000_0003, 8'd0, 3'd0, 1};
    rv[2] = '{1'b1, 3'b001, 32'h8000_0006, 1, 32'h8000_0006, 8'd0, 3'd1, 1};
    rv[3] = '{1'b0, 3'b010, 32'hBFC0_0004, 0, 32'hBFC0_0004, 8'd0, 3'd2, 1};
    rv[4] = '{1'b1, 3'b100, 32'h0000_207C, 1, 32'h0000_2060, 8'd7, 3'd2, 8};
    wv[0] = '{3'b001, 32'hBFAF_8002, 4'b1100, 32'h5A5A_0000, 32'hBFAF_8002, 8'd0, 3'd1, 4'b1100, 1'b0, 3};
    wv[1] = '{3'b100, 32'h0000_1000, 4'b0000, 32'hA000_0000, 32'h0000_1000, 8'd7, 3'd2, 4'b1111, 1'b1, 1};
    wv[2] = '{3'b010, 32'h8000_0010, 4'b1111, 32'h1234_5670, 32'h8000_0010, 8'd0, 3'd2, 4'b1111, 1'b0, 0};

    aresetn = 0;
    inst_rd_req = 0; inst_rd_type = 0; inst_rd_addr = 0;
    data_rd_req = 0; data_rd_type = 0; data_rd_addr = 0;
    data_wr_req = 0; data_wr_type = 0; data_wr_addr = 0; data_wr_wstrb = 0; data_wr_data = '0;
    arready = 0; rid = 0; rdata = 0; rlast = 0; rvalid = 0;
    awready = 0; wready = 0; bvalid = 0;
    repeat (2) @(posedge aclk);
    #1;
    check("rst_arvalid", arvalid, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_rready", rready, 0);
    check("rst_bready", bready, 0);
    check("rst_wlast", wlast, 0);
    check("rst_araddr", araddr, 0);
    check("rst_awaddr", awaddr, 0);
    check("rst_arlen", arlen, 0);
    check("rst_awlen", awlen, 0);
    check("tie_arburst", arburst, 2'b01);
    check("tie_awburst", awburst, 2'b01);
    check("tie_awid", awid, 4'd1);
    aresetn = 1;
    tick();

    // Read mapping table.
    for (int v = 0; v < 5; v++) begin
      rd_start(rv[v].is_data, rv[v].typ, rv[v].addr);
      ar_phase(rv[v].ar_delay, rv[v].exp_addr, rv[v].exp_len, rv[v].exp_size, {3'b000, rv[v].is_data});
      r_phase(rv[v].beats, rv[v].beats, {3'b000, rv[v].is_data}, rv[v].is_data);
    end

    // Write mapping table.
    for (int v = 0; v < 3; v++) begin
      wr_start(wv[v].typ, wv[v].addr, wv[v].strb, mk_payload(wv[v].seed));
      aw_phase(1, wv[v].exp_addr, wv[v].exp_len, wv[v].exp_size);
      w_phase(int'(wv[v].exp_len) + 1, wv[v].seed, wv[v].exp_strb, wv[v].toggle);
      b_phase(wv[v].b_delay);
    end

    // Simultaneous requests: data first, inst granted the cycle after data's rlast beat.
    inst_rd_req = 1; inst_rd_type = 3'b100; inst_rd_addr = 32'h1FC0_0040;
    data_rd_req = 1; data_rd_type = 3'b010; data_rd_addr = 32'h0000_0100;
    @(negedge aclk);
    check("arb_data_rdy", data_rd_rdy, 1);
    check("arb_inst_rdy", inst_rd_rdy, 0);
    tick();
    data_rd_req = 0;
    ar_phase(0, 32'h0000_0100, 8'd0, 3'd2, 4'd1);
    rvalid = 1; rid = 4'd0; rdata = 32'hDEAD_BEEF; rlast = 1;
    @(negedge aclk);
    check("wrong_rid_rready", rready, 1);
    check("arb_inst_blocked", inst_rd_rdy, 0);
    tick();
    rid = 4'd1; rdata = 32'h0BAD_F00D; rlast = 1;
    exp_q.push_back('{1'b1, 32'h0BAD_F00D, 1'b1});
    @(negedge aclk);
    check("arb_inst_blocked_last", inst_rd_rdy, 0);
    tick();
    rvalid = 0; rlast = 0;
    @(negedge aclk);
    check("arb_inst_grant", inst_rd_rdy, 1);
    check("arb_data_idle", data_rd_rdy, 0);
    tick();
    inst_rd_req = 0;
    ar_phase(0, 32'h1FC0_0040, 8'd7, 3'd2, 4'd0);
    r_phase(8, 8, 4'd0, 1'b0);

    // RAW: read to the in-flight write line stalls; other line proceeds.
    wr_start(3'b100, 32'h0000_1000, 4'h0, mk_payload(32'hC000_0000));
    aw_phase(0, 32'h0000_1000, 8'd7, 3'd2);
    w_phase(8, 32'hC000_0000, 4'hF, 1'b0);
    data_rd_req = 1; data_rd_type = 3'b010; data_rd_addr = 32'h0000_1010;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      check("raw_stall_pre", data_rd_rdy, 0);
      tick();
    end
    data_rd_addr = 32'h0000_2000;
    @(negedge aclk);
    check("raw_other_line_rdy", data_rd_rdy, 1);
    tick();
    data_rd_req = 0;
    ar_phase(0, 32'h0000_2000, 8'd0, 3'd2, 4'd1);
    r_phase(1, 1, 4'd1, 1'b1);
    data_rd_req = 1; data_rd_addr = 32'h0000_1010;
    for (int i = 0; i <= 6; i++) begin
      bvalid = (i == 6);
      @(negedge aclk);
      check("raw_stall", data_rd_rdy, 0);
      check("raw_bready", bready, 1);
      tick();
    end
    bvalid = 0;
    @(negedge aclk);
    check("raw_release", data_rd_rdy, 1);
    check("raw_wr_rdy_after_b", data_wr_rdy, 1);
    #1 data_wr_req = 0;
    tick();
    data_rd_req = 0;
    ar_phase(0, 32'h0000_1010, 8'd0, 3'd2, 4'd1);
    r_phase(1, 1, 4'd1, 1'b1);

    // Reset during beat 3 of an inst line read.
    rd_start(1'b0, 3'b100, 32'h0000_3000);
    ar_phase(0, 32'h0000_3000, 8'd7, 3'd2, 4'd0);
    r_phase(3, 8, 4'd0, 1'b0);
    rvalid = 1; rid = 4'd0; rdata = 32'h3333_3333; rlast = 0;
    inst_rd_req = 1; inst_rd_type = 3'b010; inst_rd_addr = 32'h0000_0040;
    data_wr_req = 1; data_wr_type = 3'b010; data_wr_addr = 32'h0000_0080; data_wr_wstrb = 4'hF;
    #2 aresetn = 0;
    #1;
    check("arst_inst_ret_valid", inst_ret_valid, 0);
    check("arst_ret_data", ret_data, 0);
    check("arst_rready", rready, 0);
    check("arst_arvalid", arvalid, 0);
    check("arst_araddr", araddr, 0);
    check("arst_arlen", arlen, 0);
    check("arst_inst_rd_rdy", inst_rd_rdy, 0);
    check("arst_wr_rdy", data_wr_rdy, 0);
    check("arst_awvalid", awvalid, 0);
    check("arst_wvalid", wvalid, 0);
    rvalid = 0;
    tick();
    check("arst_hold_rready", rready, 0);
    #1 aresetn = 1;
    #1;
    check("post_rst_inst_rdy", inst_rd_rdy, 1);
    check("post_rst_wr_rdy", data_wr_rdy, 1);
    check("post_rst_arvalid", arvalid, 0);
    inst_rd_req = 0;
    data_wr_req = 0;
    tick();
    tick();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
